axi_rdata_chm: RTL and testbench

//  Read-data return path of the AXI MMU. Buffers R beats from the downstream memory slave and returns them
//  to the upstream master, strictly in address-issue order. A read whose translation succeeded ("done")

---
 rtl/axi_mmu_pkg.sv | 38 +++
 rtl/axi_rdata_chm_if.sv | 37 +++
 rtl/synch_fifo.sv | 86 ++++++++
 rtl/axi_rdata_chm.sv | 241 ++++++++++++++++++++++++
 tb/tb_axi_rdata_chm.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_mmu_pkg.sv
// Shared definitions for the AXI MMU read-data return path.
//  - AXI RRESP encodings
//  - rdata_state_t: return-path FSM states
//  - Bit offsets of the packed beat {ruser, rresp, rdata, rlast} held in the data FIFO
//  - Layout of a pending-read command {is_drop, len[7:0]}
package axi_mmu_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } rdata_state_t;

    // Packed beat layout, LSB first: rlast, rdata, rresp, ruser.
    localparam int BEAT_RLAST_OFS = 0;
    localparam int BEAT_RDATA_OFS = 1;

    function automatic int beat_rresp_ofs(input int data_width);
        return BEAT_RDATA_OFS + data_width;
    endfunction

    function automatic int beat_ruser_ofs(input int data_width);
        return BEAT_RDATA_OFS + data_width + 2;
    endfunction

    function automatic int beat_width(input int data_width, input int user_width);
        return user_width + 2 + data_width + 1;
    endfunction

    // Command entry: bit 8 = is_drop, bits 7:0 = ARLEN of a dropped read.
    localparam int CMD_WIDTH    = 9;
    localparam int CMD_DROP_BIT = 8;

endpackage

// File: rtl/axi_rdata_chm_if.sv
// AXI read-data (R) channel bundle.
//  Signals: rdata, rresp, ruser, rlast, rvalid (driven by the data source),
//           rready (driven by the data sink).
//  Modports:
//   slave  - the side that returns read data (drives rdata..rvalid, receives rready)
//   master - the side that receives read data (receives rdata..rvalid, drives rready)
interface axi_rdata_chm_if #(
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 2
);

    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic [USER_WIDTH-1:0] ruser;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport slave (
        output rdata,
        output rresp,
        output ruser,
        output rlast,
        output rvalid,
        input  rready
    );

    modport master (
        input  rdata,
        input  rresp,
        input  ruser,
        input  rlast,
        input  rvalid,
        output rready
    );

endinterface

// File: rtl/synch_fifo.sv
// Single-clock show-ahead FIFO with two write ports and one read port.
//  Port 0 is written before port 1 when both are requested in the same cycle;
//  a write that finds no room is refused (wr_ack low) and the data is discarded.
//  Free space is judged from the current occupancy, so a pop in the same cycle
//  does not make room for a push.
// Ports:
//  clk, reset_   clock, asynchronous active-low reset (clears pointers/count)
//  wr_en[1:0]    write requests, port 0 has priority
//  wr_data[1:0]  write data per port
//  wr_ack[1:0]   write request accepted this cycle
//  rd_en         pop the head entry (ignored when empty)
//  rd_data       head entry (valid while empty=0)
//  empty         no entries stored
//  avail         registered "not full"; low during and for 1 cycle after reset
// DEPTH must be a power of two (pointers wrap naturally).
module synch_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 16
) (
    input  logic                clk,
    input  logic                reset_,
    input  logic [1:0]          wr_en,
    input  logic [1:0][DW-1:0]  wr_data,
    output logic [1:0]          wr_ack,
    input  logic                rd_en,
    output logic [DW-1:0]       rd_data,
    output logic                empty,
    output logic                avail
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DW-1:0] mem_array [DEPTH];

    logic [AW-1:0]       wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]       rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]       count_reg, count_next;
    logic [CW-1:0]       count_after_0;
    logic                avail_reg;
    logic [1:0]          wr_ok;
    logic [1:0][AW-1:0]  wr_addr;
    logic                pop;

    always_comb begin
        wr_ok[0]      = wr_en[0] && (count_reg < DEPTH_C);
        count_after_0 = count_reg + CW'(wr_ok[0]);
        wr_ok[1]      = wr_en[1] && (count_after_0 < DEPTH_C);
        // Port 1 lands just behind port 0 when both are taken.
        wr_addr[0]    = wr_ptr_reg;
        wr_addr[1]    = wr_ptr_reg + AW'(wr_ok[0]);
        pop           = rd_en && (count_reg != '0);
        wr_ptr_next   = wr_ptr_reg + AW'(wr_ok[0]) + AW'(wr_ok[1]);
        rd_ptr_next   = rd_ptr_reg + AW'(pop);
        count_next    = count_after_0 + CW'(wr_ok[1]) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (wr_ok[i]) begin
                mem_array[wr_addr[i]] <= wr_data[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            avail_reg  <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            avail_reg  <= (count_next < DEPTH_C);
        end
    end

    assign wr_ack  = wr_ok;
    assign rd_data = mem_array[rd_ptr_reg];
    assign empty   = (count_reg == '0);
    assign avail   = avail_reg;

endmodule

// File: rtl/axi_rdata_chm.sv
// Read-data return path of the AXI MMU.
//  Buffers R beats from the memory slave and returns them to the upstream
//  master in address-issue order. Translated reads ("done") pass memory data
//  through unchanged; failed translations ("drop") never reach memory, so an
//  error burst of drop_len+1 beats is synthesised in their place.
// Ports:
//  clk        clock
//  reset_     asynchronous reset, active low
//  mem        R channel from memory (this block is the receiver); rready = data FIFO not full
//  up         R channel to the master (this block is the source), registered outputs
//  done       1-cycle pulse: a translated read was forwarded to memory
//  drop       1-cycle pulse: a read failed translation
//  drop_len   ARLEN of the dropped read, sampled with drop
//  drop_done  1-cycle pulse: last synthetic beat accepted by the master
//  cmd_ovf    sticky: a done/drop found the command queue full
module axi_rdata_chm
    import axi_mmu_pkg::*;
#(
    parameter int         BUF_SZ     = 256,
    parameter int         CMD_DEPTH  = 16,
    parameter int         DATA_WIDTH = 32,
    parameter int         USER_WIDTH = 2,
    parameter logic [1:0] ERR_RESP   = RESP_DECERR
) (
    input  logic              clk,
    input  logic              reset_,
    axi_rdata_chm_if.master   mem,
    axi_rdata_chm_if.slave    up,
    input  logic              done,
    input  logic              drop,
    input  logic [7:0]        drop_len,
    output logic              drop_done,
    output logic              cmd_ovf
);

    localparam int BEAT_W    = beat_width(DATA_WIDTH, USER_WIDTH);
    localparam int RRESP_OFS = beat_rresp_ofs(DATA_WIDTH);
    localparam int RUSER_OFS = beat_ruser_ofs(DATA_WIDTH);

    // ------------------------------------------------------------------
    // Data FIFO: pass-through beats only
    // ------------------------------------------------------------------
    logic [1:0]              data_wr_en;
    logic [1:0][BEAT_W-1:0]  data_wr_data;
    logic [1:0]              data_wr_ack;
    logic                    data_rd_en;
    logic [BEAT_W-1:0]       data_head;
    logic                    data_empty;
    logic                    data_avail;

    assign data_wr_en      = {1'b0, mem.rvalid & data_avail};
    assign data_wr_data[0] = {mem.ruser, mem.rresp, mem.rdata, mem.rlast};
    assign data_wr_data[1] = '0;
    assign mem.rready      = data_avail;

    synch_fifo #(
        .DW    (BEAT_W),
        .DEPTH (BUF_SZ)
    ) u_data_fifo (
        .clk     (clk),
        .reset_  (reset_),
        .wr_en   (data_wr_en),
        .wr_data (data_wr_data),
        .wr_ack  (data_wr_ack),
        .rd_en   (data_rd_en),
        .rd_data (data_head),
        .empty   (data_empty),
        .avail   (data_avail)
    );

    logic [DATA_WIDTH-1:0] head_rdata;
    logic [1:0]            head_rresp;
    logic [USER_WIDTH-1:0] head_ruser;
    logic                  head_rlast;

    assign head_rlast = data_head[BEAT_RLAST_OFS];
    assign head_rdata = data_head[RRESP_OFS-1:BEAT_RDATA_OFS];
    assign head_rresp = data_head[RUSER_OFS-1:RRESP_OFS];
    assign head_ruser = data_head[BEAT_W-1:RUSER_OFS];

    // ------------------------------------------------------------------
    // Command queue: done on port 0, drop on port 1, so a same-cycle pair
    // is queued done-then-drop.
    // ------------------------------------------------------------------
    logic [1:0]                 cmd_wr_en;
    logic [1:0][CMD_WIDTH-1:0]  cmd_wr_data;
    logic [1:0]                 cmd_wr_ack;
    logic                       cmd_rd_en;
    logic [CMD_WIDTH-1:0]       cmd_head;
    logic                       cmd_empty;
    logic                       cmd_avail;
    logic                       cmd_rejected;

    assign cmd_wr_en      = {drop, done};
    assign cmd_wr_data[0] = {1'b0, 8'h00};
    assign cmd_wr_data[1] = {1'b1, drop_len};
    assign cmd_rejected   = |(cmd_wr_en & ~cmd_wr_ack);

    synch_fifo #(
        .DW    (CMD_WIDTH),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .reset_  (reset_),
        .wr_en   (cmd_wr_en),
        .wr_data (cmd_wr_data),
        .wr_ack  (cmd_wr_ack),
        .rd_en   (cmd_rd_en),
        .rd_data (cmd_head),
        .empty   (cmd_empty),
        .avail   (cmd_avail)
    );

    // Write acknowledges of the data FIFO and the cmd FIFO's avail flag are
    // not needed: data writes are already gated by avail, and cmd overflow
    // is detected from the acknowledges.
    logic unused_sig;
    assign unused_sig = ^{data_wr_ack, cmd_avail};

    // ------------------------------------------------------------------
    // FSM and output register
    // ------------------------------------------------------------------
    rdata_state_t          state_reg, state_next;
    logic [7:0]            beat_cnt_reg, beat_cnt_next;
    logic [DATA_WIDTH-1:0] rdata_reg, rdata_next;
    logic [1:0]            rresp_reg, rresp_next;
    logic [USER_WIDTH-1:0] ruser_reg, ruser_next;
    logic                  rlast_reg, rlast_next;
    logic                  rvalid_reg, rvalid_next;
    logic                  ovf_reg;
    logic                  accept;

    assign accept = rvalid_reg & up.rready;

    always_comb begin
        state_next    = state_reg;
        beat_cnt_next = beat_cnt_reg;
        rdata_next    = rdata_reg;
        rresp_next    = rresp_reg;
        ruser_next    = ruser_reg;
        rlast_next    = rlast_reg;
        rvalid_next   = rvalid_reg;
        cmd_rd_en     = 1'b0;
        data_rd_en    = 1'b0;

        unique case (state_reg)
            IDLE: begin
                // The output register is always empty here, so the first beat
                // of the next burst is loaded in the same cycle as the pop.
                if (!cmd_empty) begin
                    cmd_rd_en = 1'b1;
                    if (cmd_head[CMD_DROP_BIT]) begin
                        state_next    = DROP;
                        beat_cnt_next = cmd_head[7:0];
                        rdata_next    = '0;
                        rresp_next    = ERR_RESP;
                        ruser_next    = '0;
                        rlast_next    = (cmd_head[7:0] == 8'd0);
                        rvalid_next   = 1'b1;
                    end else begin
                        state_next = PASS;
                        data_rd_en = !data_empty;
                    end
                end
            end

            PASS: begin
                if (accept && rlast_reg) begin
                    // Any FIFO beat now belongs to a later burst; wait for its command.
                    state_next  = IDLE;
                    rvalid_next = 1'b0;
                    rlast_next  = 1'b0;
                end else if (!data_empty && (!rvalid_reg || up.rready)) begin
                    data_rd_en = 1'b1;
                end else if (accept) begin
                    rvalid_next = 1'b0;
                end
            end

            DROP: begin
                if (accept) begin
                    if (rlast_reg) begin
                        state_next  = IDLE;
                        rvalid_next = 1'b0;
                        rlast_next  = 1'b0;
                    end else begin
                        // beat_cnt counts beats still to follow the one on the bus.
                        beat_cnt_next = beat_cnt_reg - 8'd1;
                        rlast_next    = (beat_cnt_reg == 8'd1);
                    end
                end
            end

            default: begin
                state_next  = IDLE;
                rvalid_next = 1'b0;
                rlast_next  = 1'b0;
            end
        endcase

        if (data_rd_en) begin
            rdata_next  = head_rdata;
            rresp_next  = head_rresp;
            ruser_next  = head_ruser;
            rlast_next  = head_rlast;
            rvalid_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_reg    <= IDLE;
            beat_cnt_reg <= '0;
            rdata_reg    <= '0;
            rresp_reg    <= '0;
            ruser_reg    <= '0;
            rlast_reg    <= 1'b0;
            rvalid_reg   <= 1'b0;
            ovf_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            beat_cnt_reg <= beat_cnt_next;
            rdata_reg    <= rdata_next;
            rresp_reg    <= rresp_next;
            ruser_reg    <= ruser_next;
            rlast_reg    <= rlast_next;
            rvalid_reg   <= rvalid_next;
            ovf_reg      <= ovf_reg | cmd_rejected;
        end
    end

    assign up.rdata  = rdata_reg;
    assign up.rresp  = rresp_reg;
    assign up.ruser  = ruser_reg;
    assign up.rlast  = rlast_reg;
    assign up.rvalid = rvalid_reg;

    assign drop_done = (state_reg == DROP) && accept && rlast_reg;
    assign cmd_ovf   = ovf_reg;

endmodule

// File: tb/tb_axi_rdata_chm.sv
module tb_axi_rdata_chm;
    import axi_mmu_pkg::*;

    localparam int DW = 32;
    localparam int UW = 2;

    logic       clk = 1'b0;
    logic       reset_ = 1'b0;
    logic       done = 1'b0;
    logic       drop = 1'b0;
    logic [7:0] drop_len = 8'd0;
    logic       drop_done;
    logic       cmd_ovf;

    axi_rdata_chm_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) mem_if ();
    axi_rdata_chm_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) up_if ();

    axi_rdata_chm #(
        .BUF_SZ     (4),
        .CMD_DEPTH  (16),
        .DATA_WIDTH (DW),
        .USER_WIDTH (UW),
        .ERR_RESP   (2'b11)
    ) dut (
        .clk       (clk),
        .reset_    (reset_),
        .mem       (mem_if),
        .up        (up_if),
        .done      (done),
        .drop      (drop),
        .drop_len  (drop_len),
        .drop_done (drop_done),
        .cmd_ovf   (cmd_ovf)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int dd_total = 0;
    int in_cnt = 0;
    int first_in_cyc = -1;

    logic [31:0] q_data [$];
    logic [1:0]  q_resp [$];
    logic [1:0]  q_user [$];
    logic        q_last [$];
    logic        q_dd   [$];
    int          q_cyc  [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Beats accepted by the master, observed mid-cycle.
    always @(negedge clk) begin
        if (up_if.rvalid && up_if.rready) begin
            q_data.push_back(up_if.rdata);
            q_resp.push_back(up_if.rresp);
            q_user.push_back(up_if.ruser);
            q_last.push_back(up_if.rlast);
            q_dd.push_back(drop_done);
            q_cyc.push_back(cyc);
            $display("beat %0d: cyc=%0d rdata=%h rresp=%b ruser=%b rlast=%b drop_done=%b",
                     q_data.size() - 1, cyc, up_if.rdata, up_if.rresp, up_if.ruser,
                     up_if.rlast, drop_done);
        end
        if (drop_done) dd_total = dd_total + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic d, input logic p, input logic [7:0] len);
        done = d;
        drop = p;
        drop_len = len;
        tick();
        done = 1'b0;
        drop = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [1:0] r, input logic l);
        bit ok;
        ok = 1'b0;
        mem_if.rdata  = d;
        mem_if.rresp  = r;
        mem_if.ruser  = d[1:0];
        mem_if.rlast  = l;
        mem_if.rvalid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = mem_if.rready;
            if (ok) begin
                if (first_in_cyc < 0) first_in_cyc = cyc;
                in_cnt = in_cnt + 1;
            end
            @(posedge clk);
            #1;
        end
        mem_if.rvalid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_beat: beat %h not accepted, rready=%b required 1", d, mem_if.rready);
        end
    endtask

    task automatic wait_beats(input int base, input int n, input string name);
        for (int i = 0; i < 3000 && q_data.size() < base + n; i++) tick();
        checks++;
        if (q_data.size() < base + n) begin
            errors++;
            $display("FAIL %s: beats seen=%0d required=%0d", name, q_data.size() - base, n);
        end
    endtask

    task automatic test_reset();
        mem_if.rdata = '0; mem_if.rresp = '0; mem_if.ruser = '0;
        mem_if.rlast = 1'b0; mem_if.rvalid = 1'b0;
        up_if.rready = 1'b1;
        reset_ = 1'b0;
        repeat (3) tick();
        checks++;
        if ({mem_if.rready, up_if.rvalid, up_if.rlast, drop_done, cmd_ovf} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: {mrready,srvalid,rlast,drop_done,cmd_ovf}=%b required 00000",
                     {mem_if.rready, up_if.rvalid, up_if.rlast, drop_done, cmd_ovf});
        end
        checks++;
        if ({up_if.rdata, up_if.rresp, up_if.ruser} !== '0) begin
            errors++;
            $display("FAIL reset_data: rdata=%h rresp=%b ruser=%b required all 0",
                     up_if.rdata, up_if.rresp, up_if.ruser);
        end
        #2 reset_ = 1'b1;
        #1;
        checks++;
        if (mem_if.rready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: mrready=%b required 0 before first edge", mem_if.rready);
        end
        tick();
        checks++;
        if (mem_if.rready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mrready_rise: mrready=%b required 1", mem_if.rready);
        end
        $display("test_reset done");
    endtask

    task automatic test_pass();
        logic [31:0] exp_d [4] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        int base;
        base = q_data.size();
        first_in_cyc = -1;
        up_if.rready = 1'b1;
        pulse(1'b1, 1'b0, 8'd0);
        tick();
        for (int i = 0; i < 4; i++) send_beat(exp_d[i], 2'b00, i == 3);
        wait_beats(base, 4, "pass_count");
        for (int i = 0; i < 4 && base + i < q_data.size(); i++) begin
            checks++;
            if (q_data[base+i] !== exp_d[i] || q_last[base+i] !== (i == 3) ||
                q_resp[base+i] !== 2'b00 || q_user[base+i] !== exp_d[i][1:0]) begin
                errors++;
                $display("FAIL pass_beat%0d: data=%h last=%b resp=%b user=%b required %h %b 00 %b",
                         i, q_data[base+i], q_last[base+i], q_resp[base+i], q_user[base+i],
                         exp_d[i], (i == 3), exp_d[i][1:0]);
            end
        end
        if (q_cyc.size() > base) begin
            checks++;
            if (q_cyc[base] - first_in_cyc != 2) begin
                errors++;
                $display("FAIL pass_latency: cycles=%0d required 2", q_cyc[base] - first_in_cyc);
            end
        end
        $display("test_pass done");
    endtask

    task automatic test_drop();
        int base, d0;
        base = q_data.size();
        d0 = dd_total;
        pulse(1'b0, 1'b1, 8'd3);
        wait_beats(base, 4, "drop_count");
        for (int i = 0; i < 4 && base + i < q_data.size(); i++) begin
            checks++;
            if (q_data[base+i] !== 32'h0 || q_resp[base+i] !== 2'b11 ||
                q_last[base+i] !== (i == 3) || q_dd[base+i] !== (i == 3)) begin
                errors++;
                $display("FAIL drop_beat%0d: data=%h resp=%b last=%b dd=%b required 0 11 %b %b",
                         i, q_data[base+i], q_resp[base+i], q_last[base+i], q_dd[base+i],
                         (i == 3), (i == 3));
            end
        end
        repeat (3) tick();
        checks++;
        if (dd_total - d0 != 1) begin
            errors++;
            $display("FAIL drop_done_count: pulses=%0d required 1", dd_total - d0);
        end
        $display("test_drop done");
    endtask

    task automatic test_interleave();
        logic [31:0] exp_d [6] = '{32'h10, 32'h11, 32'h0, 32'h0, 32'h20, 32'h21};
        logic [1:0]  exp_r [6] = '{2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00};
        logic        exp_l [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        int base;
        base = q_data.size();
        pulse(1'b1, 1'b0, 8'd0);
        pulse(1'b0, 1'b1, 8'd1);
        pulse(1'b1, 1'b0, 8'd0);
        send_beat(32'h10, 2'b00, 1'b0);
        send_beat(32'h11, 2'b00, 1'b1);
        send_beat(32'h20, 2'b00, 1'b0);
        send_beat(32'h21, 2'b00, 1'b1);
        wait_beats(base, 6, "interleave_count");
        for (int i = 0; i < 6 && base + i < q_data.size(); i++) begin
            checks++;
            if (q_data[base+i] !== exp_d[i] || q_resp[base+i] !== exp_r[i] ||
                q_last[base+i] !== exp_l[i]) begin
                errors++;
                $display("FAIL interleave_beat%0d: data=%h resp=%b last=%b required %h %b %b",
                         i, q_data[base+i], q_resp[base+i], q_last[base+i],
                         exp_d[i], exp_r[i], exp_l[i]);
            end
        end
        $display("test_interleave done");
    endtask

    task automatic test_backpressure();
        int base;
        bit stable;
        base = q_data.size();
        up_if.rready = 1'b0;
        in_cnt = 0;
        pulse(1'b1, 1'b0, 8'd0);
        fork
            begin
                for (int i = 0; i < 8; i++) send_beat(32'hB0 + 32'(i), 2'(i), i == 7);
            end
            begin
                repeat (4) tick();
                stable = 1'b1;
                for (int i = 0; i < 16; i++) begin
                    tick();
                    if (up_if.rvalid !== 1'b1 || up_if.rdata !== 32'hB0 ||
                        up_if.rresp !== 2'b00 || up_if.rlast !== 1'b0) stable = 1'b0;
                end
                checks++;
                if (!stable) begin
                    errors++;
                    $display("FAIL bp_hold: srvalid=%b rdata=%h required 1 b0 held", up_if.rvalid, up_if.rdata);
                end
                checks++;
                if (mem_if.rready !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_mrready: mrready=%b required 0", mem_if.rready);
                end
                checks++;
                if (in_cnt != 5) begin
                    errors++;
                    $display("FAIL bp_stored: accepted=%0d required 5", in_cnt);
                end
                up_if.rready = 1'b1;
            end
        join
        wait_beats(base, 8, "bp_count");
        for (int i = 0; i < 8 && base + i < q_data.size(); i++) begin
            checks++;
            if (q_data[base+i] !== 32'hB0 + 32'(i) || q_resp[base+i] !== 2'(i) ||
                q_last[base+i] !== (i == 7)) begin
                errors++;
                $display("FAIL bp_beat%0d: data=%h resp=%b last=%b required %h %b %b",
                         i, q_data[base+i], q_resp[base+i], q_last[base+i],
                         32'hB0 + 32'(i), 2'(i), (i == 7));
            end
        end
        $display("test_backpressure done");
    endtask

    task automatic test_same_cycle();
        int base, d0;
        base = q_data.size();
        d0 = dd_total;
        pulse(1'b1, 1'b1, 8'd0);
        send_beat(32'h55, 2'b10, 1'b1);
        wait_beats(base, 2, "same_cycle_count");
        if (q_data.size() >= base + 2) begin
            checks++;
            if (q_data[base] !== 32'h55 || q_resp[base] !== 2'b10 || q_last[base] !== 1'b1) begin
                errors++;
                $display("FAIL same_cycle_pass: data=%h resp=%b last=%b required 55 10 1",
                         q_data[base], q_resp[base], q_last[base]);
            end
            checks++;
            if (q_data[base+1] !== 32'h0 || q_resp[base+1] !== 2'b11 || q_last[base+1] !== 1'b1 ||
                q_dd[base+1] !== 1'b1) begin
                errors++;
                $display("FAIL same_cycle_err: data=%h resp=%b last=%b dd=%b required 0 11 1 1",
                         q_data[base+1], q_resp[base+1], q_last[base+1], q_dd[base+1]);
            end
        end
        repeat (2) tick();
        checks++;
        if (dd_total - d0 != 1) begin
            errors++;
            $display("FAIL same_cycle_dd: pulses=%0d required 1", dd_total - d0);
        end
        $display("test_same_cycle done");
    endtask

    task automatic test_drop_max();
        int base, d0, lasts, bad;
        base = q_data.size();
        d0 = dd_total;
        pulse(1'b0, 1'b1, 8'd255);
        wait_beats(base, 256, "drop_max_count");
        repeat (5) tick();
        lasts = 0;
        bad = 0;
        for (int i = base; i < q_data.size(); i++) begin
            if (q_last[i]) lasts++;
            if (q_resp[i] !== 2'b11 || q_data[i] !== 32'h0) bad++;
        end
        checks++;
        if (q_data.size() - base != 256 || lasts != 1 || bad != 0) begin
            errors++;
            $display("FAIL drop_max: beats=%0d lasts=%0d bad=%0d required 256 1 0",
                     q_data.size() - base, lasts, bad);
        end
        if (q_data.size() >= base + 256) begin
            checks++;
            if (q_last[base+255] !== 1'b1 || q_dd[base+255] !== 1'b1) begin
                errors++;
                $display("FAIL drop_max_last: last=%b dd=%b required 1 1", q_last[base+255], q_dd[base+255]);
            end
        end
        checks++;
        if (dd_total - d0 != 1) begin
            errors++;
            $display("FAIL drop_max_dd: pulses=%0d required 1", dd_total - d0);
        end
        $display("test_drop_max done");
    endtask

    task automatic test_reset_mid();
        int base;
        up_if.rready = 1'b1;
        pulse(1'b1, 1'b0, 8'd0);
        pulse(1'b0, 1'b1, 8'd0);
        base = q_data.size();
        send_beat(32'h40, 2'b00, 1'b0);
        wait_beats(base, 1, "reset_mid_first");
        up_if.rready = 1'b0;
        send_beat(32'h41, 2'b00, 1'b0);
        repeat (2) tick();
        checks++;
        if (up_if.rvalid !== 1'b1 || up_if.rdata !== 32'h41) begin
            errors++;
            $display("FAIL reset_mid_pre: srvalid=%b rdata=%h required 1 41", up_if.rvalid, up_if.rdata);
        end
        #2 reset_ = 1'b0;
        #1;
        checks++;
        if ({up_if.rvalid, up_if.rlast, mem_if.rready} !== 3'b0 || up_if.rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_async: srvalid=%b rlast=%b mrready=%b rdata=%h required all 0",
                     up_if.rvalid, up_if.rlast, mem_if.rready, up_if.rdata);
        end
        tick();
        reset_ = 1'b1;
        repeat (2) tick();
        up_if.rready = 1'b1;
        base = q_data.size();
        pulse(1'b1, 1'b0, 8'd0);
        send_beat(32'h50, 2'b00, 1'b0);
        send_beat(32'h51, 2'b00, 1'b1);
        wait_beats(base, 2, "reset_mid_after");
        repeat (10) tick();
        checks++;
        if (q_data.size() - base != 2) begin
            errors++;
            $display("FAIL reset_mid_stale: beats=%0d required 2", q_data.size() - base);
        end
        if (q_data.size() >= base + 2) begin
            checks++;
            if (q_data[base] !== 32'h50 || q_data[base+1] !== 32'h51 ||
                q_last[base] !== 1'b0 || q_last[base+1] !== 1'b1 || q_resp[base+1] !== 2'b00) begin
                errors++;
                $display("FAIL reset_mid_data: data=%h,%h last=%b,%b required 50,51 0,1",
                         q_data[base], q_data[base+1], q_last[base], q_last[base+1]);
            end
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_ovf();
        up_if.rready = 1'b0;
        checks++;
        if (cmd_ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_initial: cmd_ovf=%b required 0", cmd_ovf);
        end
        for (int i = 0; i < 8; i++) pulse(1'b1, 1'b1, 8'd0);
        checks++;
        if (cmd_ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_at_15: cmd_ovf=%b required 0", cmd_ovf);
        end
        pulse(1'b1, 1'b1, 8'd0);
        checks++;
        if (cmd_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: cmd_ovf=%b required 1", cmd_ovf);
        end
        repeat (3) tick();
        checks++;
        if (cmd_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: cmd_ovf=%b required 1", cmd_ovf);
        end
        #2 reset_ = 1'b0;
        #1;
        checks++;
        if (cmd_ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_reset: cmd_ovf=%b required 0", cmd_ovf);
        end
        tick();
        reset_ = 1'b1;
        tick();
        $display("test_ovf done");
    endtask

    initial begin
        test_reset();
        test_pass();
        test_drop();
        test_interleave();
        test_backpressure();
        test_same_cycle();
        test_drop_max();
        test_reset_mid();
        test_ovf();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
